// File: rtl/pipeline_control.sv
// ----------------------------------------------------------------------------
// pipeline_control
//
// Central controller for a 5-stage (F/D/E/M/W) MIPS-subset pipeline. It
// decodes the D-stage instruction, carries the decoded form and the resolved
// destination register down internal E/M/W registers, and from those produces
// the per-stage control words, forwarding-mux selects and stall enables.
// It holds no datapath state of its own.
//
// Ports:
//   clk                   rising-edge clock
//   reset                 asynchronous active-high; E/M/W registers -> nop
//   d_instr[31:0]         instruction currently in D
//   rf_read_result2[31:0] raw RF read of rt for the D instruction (movz test)
//   cw_f_pc_enable        PC write enable (0 = stall)
//   cw_d_pff_enable       F/D register enable (0 = stall)
//   cw_f_npc_jump_mode    0 PC+4, 1 beq, 2 j/jal, 3 jr
//   cw_d_ext_mode         0 zero-ext, 1 sign-ext, 2 imm<<16
//   cw_d_rf_read_addr1/2  rs / rt of d_instr
//   cw_e_m_alusrc         ALU B source: 0 register, 1 extended immediate
//   cw_e_alu_op           0 add, 1 sub, 2 or, 3 pass B, 4 pass A
//   cw_m_dm_write_enable  sw in M
//   cw_w_rf_write_enable  W instruction writes a nonzero register
//   cw_w_m_regdata        0 ALU, 1 DM, 2 PC+8
//   cw_w_rf_write_addr    resolved destination of the W instruction
//   cw_fm_d1/d2           D operand select: 0 RF, 1 E2D_rf, 2 E2D_npc,
//                         3 M2D_alu, 4 M2D_npc, 5 W2D_rf
//   cw_fm_e1/e2           E operand select: 0 pipe, 1 M2E_alu, 2 M2E_npc,
//                         3 W2E_rf
//   cw_fm_m               M store-data select: 0 pipe, 1 W2M_rf
//
// Handshake: there is no valid/ready pair here; the only flow control is the
// stall, during which the PC and F/D register hold (enables = 0), a bubble
// enters E, and M/W keep advancing.
// ----------------------------------------------------------------------------
module pipeline_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_instr,
  input  logic [31:0] rf_read_result2,
  output logic        cw_f_pc_enable,
  output logic        cw_d_pff_enable,
  output logic [2:0]  cw_f_npc_jump_mode,
  output logic [2:0]  cw_d_ext_mode,
  output logic [4:0]  cw_d_rf_read_addr1,
  output logic [4:0]  cw_d_rf_read_addr2,
  output logic        cw_e_m_alusrc,
  output logic [4:0]  cw_e_alu_op,
  output logic        cw_m_dm_write_enable,
  output logic        cw_w_rf_write_enable,
  output logic [2:0]  cw_w_m_regdata,
  output logic [4:0]  cw_w_rf_write_addr,
  output logic [2:0]  cw_fm_d1,
  output logic [2:0]  cw_fm_d2,
  output logic [2:0]  cw_fm_e1,
  output logic [2:0]  cw_fm_e2,
  output logic [2:0]  cw_fm_m
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL_A = 6'h03;
  localparam logic [5:0] OP_JAL_B = 6'h0B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_MOVZ  = 6'h0A;
  localparam logic [5:0] FN_JR    = 6'h08;

  // One-hot-ish decoded instruction; all zero is a nop.
  typedef struct packed {
    logic addu;
    logic subu;
    logic movz;
    logic jr;
    logic lui;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t r;
    r = '0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU: r.addu = 1'b1;
          FN_SUBU: r.subu = 1'b1;
          FN_MOVZ: r.movz = 1'b1;
          FN_JR:   r.jr   = 1'b1;
          default: r = '0;
        endcase
      end
      OP_LUI:             r.lui = 1'b1;
      OP_ORI:             r.ori = 1'b1;
      OP_LW:              r.lw  = 1'b1;
      OP_SW:              r.sw  = 1'b1;
      OP_BEQ:             r.beq = 1'b1;
      OP_J:               r.j   = 1'b1;
      OP_JAL_A, OP_JAL_B: r.jal = 1'b1;
      default:            r = '0;
    endcase
    return r;
  endfunction

  // Producers whose result comes out of the ALU (movz passes rs through).
  function automatic logic is_alu(input dec_t d);
    return d.addu | d.subu | d.movz | d.ori | d.lui;
  endfunction

  // Results already available while the producer sits in E.
  function automatic logic ready_in_e(input dec_t d);
    return d.movz | d.jal;
  endfunction

  function automatic logic reads_rs(input dec_t d);
    return d.addu | d.subu | d.movz | d.jr | d.ori | d.lw | d.sw | d.beq;
  endfunction

  // movz's condition uses the raw RF read, so movz is not an rt reader here.
  function automatic logic reads_rt(input dec_t d);
    return d.addu | d.subu | d.beq | d.sw;
  endfunction

  // D-stage operand select: youngest producer wins; an unready one gives 0.
  function automatic logic [2:0] sel_d(input logic [4:0] src, input logic rd,
                                       input dec_t ed, input logic [4:0] edst,
                                       input dec_t md, input logic [4:0] mdst,
                                       input logic [4:0] wdst);
    logic [2:0] s;
    s = 3'd0;
    if (rd && src != 5'd0) begin
      if (edst == src) begin
        if (ed.movz)     s = 3'd1;
        else if (ed.jal) s = 3'd2;
        else             s = 3'd0;
      end else if (mdst == src) begin
        if (is_alu(md))  s = 3'd3;
        else if (md.jal) s = 3'd4;
        else             s = 3'd0;
      end else if (wdst == src) begin
        s = 3'd5;
      end
    end
    return s;
  endfunction

  function automatic logic [2:0] sel_e(input logic [4:0] src, input logic rd,
                                       input dec_t md, input logic [4:0] mdst,
                                       input logic [4:0] wdst);
    logic [2:0] s;
    s = 3'd0;
    if (rd && src != 5'd0) begin
      if (mdst == src) begin
        if (is_alu(md))  s = 3'd1;
        else if (md.jal) s = 3'd2;
        else             s = 3'd0;
      end else if (wdst == src) begin
        s = 3'd3;
      end
    end
    return s;
  endfunction

  // A D source must wait when its youngest producer cannot deliver in time.
  function automatic logic hazard(input logic [4:0] src, input logic rd,
                                  input logic d_use, input logic e_use,
                                  input dec_t ed, input logic [4:0] edst,
                                  input dec_t md, input logic [4:0] mdst);
    logic h;
    h = 1'b0;
    if (rd && src != 5'd0) begin
      if (edst == src) begin
        h = (d_use && !ready_in_e(ed)) || (e_use && ed.lw);
      end else if (mdst == src) begin
        h = d_use && md.lw;
      end
    end
    return h;
  endfunction

  // Pipeline registers
  dec_t       e_dec_q, e_dec_d, m_dec_q, w_dec_q;
  logic [4:0] e_dst_q, e_dst_d, m_dst_q, w_dst_q;
  logic [4:0] e_rs_q,  e_rs_d;
  logic [4:0] e_rt_q,  e_rt_d, m_rt_q;

  dec_t       d_dec;
  logic [4:0] d_rs, d_rt, d_rd, d_dst;
  logic       d_use_rs, d_use_rt, e_use_rs, e_use_rt;
  logic       stall;

  assign d_rs = d_instr[25:21];
  assign d_rt = d_instr[20:16];
  assign d_rd = d_instr[15:11];

  // shamt field is never needed by this instruction subset.
  logic unused_bits;
  assign unused_bits = ^{d_instr[10:6], w_dec_q};

  always_comb begin
    d_dec    = decode(d_instr[31:26], d_instr[5:0]);
    d_dst    = 5'd0;
    if (d_dec.addu || d_dec.subu)             d_dst = d_rd;
    else if (d_dec.movz)                      d_dst = (rf_read_result2 == 32'd0) ? d_rd : 5'd0;
    else if (d_dec.lui || d_dec.ori || d_dec.lw) d_dst = d_rt;
    else if (d_dec.jal)                       d_dst = 5'd31;

    d_use_rs = d_dec.beq | d_dec.jr;
    d_use_rt = d_dec.beq;
    e_use_rs = d_dec.addu | d_dec.subu | d_dec.movz | d_dec.ori | d_dec.lw | d_dec.sw;
    e_use_rt = d_dec.addu | d_dec.subu;

    stall = hazard(d_rs, reads_rs(d_dec), d_use_rs, e_use_rs,
                   e_dec_q, e_dst_q, m_dec_q, m_dst_q)
          | hazard(d_rt, reads_rt(d_dec), d_use_rt, e_use_rt,
                   e_dec_q, e_dst_q, m_dec_q, m_dst_q);

    // A stall drops a bubble into E while D is held.
    e_dec_d = stall ? '0   : d_dec;
    e_dst_d = stall ? 5'd0 : d_dst;
    e_rs_d  = stall ? 5'd0 : d_rs;
    e_rt_d  = stall ? 5'd0 : d_rt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_dec_q <= '0;
      e_dst_q <= 5'd0;
      e_rs_q  <= 5'd0;
      e_rt_q  <= 5'd0;
      m_dec_q <= '0;
      m_dst_q <= 5'd0;
      m_rt_q  <= 5'd0;
      w_dec_q <= '0;
      w_dst_q <= 5'd0;
    end else begin
      e_dec_q <= e_dec_d;
      e_dst_q <= e_dst_d;
      e_rs_q  <= e_rs_d;
      e_rt_q  <= e_rt_d;
      m_dec_q <= e_dec_q;
      m_dst_q <= e_dst_q;
      m_rt_q  <= e_rt_q;
      w_dec_q <= m_dec_q;
      w_dst_q <= m_dst_q;
    end
  end

  always_comb begin
    cw_f_pc_enable     = ~stall;
    cw_d_pff_enable    = ~stall;

    cw_f_npc_jump_mode = 3'd0;
    if (d_dec.beq)                  cw_f_npc_jump_mode = 3'd1;
    else if (d_dec.j || d_dec.jal)  cw_f_npc_jump_mode = 3'd2;
    else if (d_dec.jr)              cw_f_npc_jump_mode = 3'd3;

    cw_d_ext_mode = 3'd0;
    if (d_dec.lw || d_dec.sw || d_dec.beq) cw_d_ext_mode = 3'd1;
    else if (d_dec.lui)                    cw_d_ext_mode = 3'd2;

    cw_d_rf_read_addr1 = d_rs;
    cw_d_rf_read_addr2 = d_rt;

    cw_e_m_alusrc = e_dec_q.ori | e_dec_q.lui | e_dec_q.lw | e_dec_q.sw;
    cw_e_alu_op   = 5'd0;
    if (e_dec_q.subu)      cw_e_alu_op = 5'd1;
    else if (e_dec_q.ori)  cw_e_alu_op = 5'd2;
    else if (e_dec_q.lui)  cw_e_alu_op = 5'd3;
    else if (e_dec_q.movz) cw_e_alu_op = 5'd4;

    cw_m_dm_write_enable = m_dec_q.sw;

    cw_w_rf_write_enable = (w_dst_q != 5'd0);
    cw_w_rf_write_addr   = w_dst_q;
    cw_w_m_regdata       = 3'd0;
    if (w_dec_q.lw)       cw_w_m_regdata = 3'd1;
    else if (w_dec_q.jal) cw_w_m_regdata = 3'd2;

    cw_fm_d1 = sel_d(d_rs, reads_rs(d_dec), e_dec_q, e_dst_q, m_dec_q, m_dst_q, w_dst_q);
    cw_fm_d2 = sel_d(d_rt, reads_rt(d_dec), e_dec_q, e_dst_q, m_dec_q, m_dst_q, w_dst_q);
    cw_fm_e1 = sel_e(e_rs_q, reads_rs(e_dec_q), m_dec_q, m_dst_q, w_dst_q);
    cw_fm_e2 = sel_e(e_rt_q, reads_rt(e_dec_q), m_dec_q, m_dst_q, w_dst_q);
    cw_fm_m  = (m_dec_q.sw && m_rt_q != 5'd0 && m_rt_q == w_dst_q) ? 3'd1 : 3'd0;
  end

endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;

  logic        clk;
  logic        reset;
  logic [31:0] d_instr;
  logic [31:0] rf_read_result2;
  logic        cw_f_pc_enable, cw_d_pff_enable;
  logic [2:0]  cw_f_npc_jump_mode, cw_d_ext_mode;
  logic [4:0]  cw_d_rf_read_addr1, cw_d_rf_read_addr2;
  logic        cw_e_m_alusrc;
  logic [4:0]  cw_e_alu_op;
  logic        cw_m_dm_write_enable, cw_w_rf_write_enable;
  logic [2:0]  cw_w_m_regdata;
  logic [4:0]  cw_w_rf_write_addr;
  logic [2:0]  cw_fm_d1, cw_fm_d2, cw_fm_e1, cw_fm_e2, cw_fm_m;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] MOVZ123 = 32'h0043_080a;  // movz $1,$2,$3
  localparam logic [31:0] ADDU011 = 32'h0021_0021;  // addu $0,$1,$1
  localparam logic [31:0] JAL     = 32'h2c00_0004;  // jal (opcode 0x0B)
  localparam logic [31:0] ADDU031 = 32'h03ff_0021;  // addu $0,$31,$31
  localparam logic [31:0] ADDU123 = 32'h0043_0821;  // addu $1,$2,$3
  localparam logic [31:0] SW1     = 32'hac41_0010;  // sw $1,16($2)
  localparam logic [31:0] LW1     = 32'h8c41_0008;  // lw $1,8($2)
  localparam logic [31:0] BEQ11   = 32'h1021_0003;  // beq $1,$1,+3
  localparam logic [31:0] ADDU412 = 32'h0022_2021;  // addu $4,$1,$2

  pipeline_control dut (
    .clk                  (clk),
    .reset                (reset),
    .d_instr              (d_instr),
    .rf_read_result2      (rf_read_result2),
    .cw_f_pc_enable       (cw_f_pc_enable),
    .cw_d_pff_enable      (cw_d_pff_enable),
    .cw_f_npc_jump_mode   (cw_f_npc_jump_mode),
    .cw_d_ext_mode        (cw_d_ext_mode),
    .cw_d_rf_read_addr1   (cw_d_rf_read_addr1),
    .cw_d_rf_read_addr2   (cw_d_rf_read_addr2),
    .cw_e_m_alusrc        (cw_e_m_alusrc),
    .cw_e_alu_op          (cw_e_alu_op),
    .cw_m_dm_write_enable (cw_m_dm_write_enable),
    .cw_w_rf_write_enable (cw_w_rf_write_enable),
    .cw_w_m_regdata       (cw_w_m_regdata),
    .cw_w_rf_write_addr   (cw_w_rf_write_addr),
    .cw_fm_d1             (cw_fm_d1),
    .cw_fm_d2             (cw_fm_d2),
    .cw_fm_e1             (cw_fm_e1),
    .cw_fm_e2             (cw_fm_e2),
    .cw_fm_m              (cw_fm_m)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] r2);
    d_instr         = ins;
    rf_read_result2 = r2;
    #1;
  endtask

  task automatic flush();
    drive(NOP, 32'd0);
    repeat (3) tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_w_we"},   {31'd0, cw_w_rf_write_enable}, 32'd0);
    check({tag, "_w_addr"}, {27'd0, cw_w_rf_write_addr},   32'd0);
    check({tag, "_w_rd"},   {29'd0, cw_w_m_regdata},       32'd0);
    check({tag, "_dm_we"},  {31'd0, cw_m_dm_write_enable}, 32'd0);
    check({tag, "_aluop"},  {27'd0, cw_e_alu_op},          32'd0);
    check({tag, "_alusrc"}, {31'd0, cw_e_m_alusrc},        32'd0);
    check({tag, "_fm"},     {17'd0, cw_fm_d1, cw_fm_d2, cw_fm_e1, cw_fm_e2, cw_fm_m}, 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    d_instr         = NOP;
    rf_read_result2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst");
    check("rst_pc_en", {31'd0, cw_f_pc_enable}, 32'd1);
    reset = 1'b0;
    flush();

    // movz $1,$2,$3 (taken) feeding addu $0,$1,$1
    drive(MOVZ123, 32'd0);
    check("movz_ra1", {27'd0, cw_d_rf_read_addr1}, 32'd2);
    check("movz_ra2", {27'd0, cw_d_rf_read_addr2}, 32'd3);
    check("movz_npc", {29'd0, cw_f_npc_jump_mode}, 32'd0);
    tick();
    drive(ADDU011, 32'd1);
    check("movz_fmd1", {29'd0, cw_fm_d1}, 32'd1);
    check("movz_fmd2", {29'd0, cw_fm_d2}, 32'd1);
    check("movz_aluop", {27'd0, cw_e_alu_op}, 32'd4);
    check("movz_pc_en", {31'd0, cw_f_pc_enable}, 32'd1);
    tick();
    drive(NOP, 32'd0);
    check("movz_fme1", {29'd0, cw_fm_e1}, 32'd1);
    check("movz_fme2", {29'd0, cw_fm_e2}, 32'd1);
    tick();
    check("movz_w_we",   {31'd0, cw_w_rf_write_enable}, 32'd1);
    check("movz_w_addr", {27'd0, cw_w_rf_write_addr},   32'd1);
    check("movz_w_rd",   {29'd0, cw_w_m_regdata},       32'd0);
    flush();

    // jal feeding addu $0,$31,$31 directly
    drive(JAL, 32'd0);
    check("jal_npc", {29'd0, cw_f_npc_jump_mode}, 32'd2);
    tick();
    drive(ADDU031, 32'd0);
    check("jal_fmd1", {29'd0, cw_fm_d1}, 32'd2);
    check("jal_fmd2", {29'd0, cw_fm_d2}, 32'd2);
    tick();
    drive(NOP, 32'd0);
    check("jal_fme1", {29'd0, cw_fm_e1}, 32'd2);
    check("jal_fme2", {29'd0, cw_fm_e2}, 32'd2);
    tick();
    check("jal_w_we",   {31'd0, cw_w_rf_write_enable}, 32'd1);
    check("jal_w_addr", {27'd0, cw_w_rf_write_addr},   32'd31);
    check("jal_w_rd",   {29'd0, cw_w_m_regdata},       32'd2);
    flush();

    // jal, nop, addu $0,$31,$31
    drive(JAL, 32'd0);
    tick();
    drive(NOP, 32'd0);
    tick();
    drive(ADDU031, 32'd0);
    check("jal2_fmd1", {29'd0, cw_fm_d1}, 32'd4);
    check("jal2_fmd2", {29'd0, cw_fm_d2}, 32'd4);
    tick();
    drive(NOP, 32'd0);
    check("jal2_fme1", {29'd0, cw_fm_e1}, 32'd3);
    flush();

    // addu $1,$2,$3 then sw $1,16($2)
    drive(ADDU123, 32'd0);
    tick();
    drive(SW1, 32'd0);
    check("sw_pc_en", {31'd0, cw_f_pc_enable}, 32'd1);
    check("sw_fmd2",  {29'd0, cw_fm_d2},       32'd0);
    check("sw_ext",   {29'd0, cw_d_ext_mode},  32'd1);
    tick();
    drive(NOP, 32'd0);
    check("sw_fme2",   {29'd0, cw_fm_e2},      32'd1);
    check("sw_fme1",   {29'd0, cw_fm_e1},      32'd0);
    check("sw_alusrc", {31'd0, cw_e_m_alusrc}, 32'd1);
    tick();
    check("sw_fmm",   {29'd0, cw_fm_m},              32'd1);
    check("sw_dm_we", {31'd0, cw_m_dm_write_enable}, 32'd1);
    flush();

    // lw $1 then beq $1,$1: two stall cycles, then W2D
    drive(LW1, 32'd0);
    check("lw_ext", {29'd0, cw_d_ext_mode}, 32'd1);
    tick();
    drive(BEQ11, 32'd0);
    check("beq_st1_pc",  {31'd0, cw_f_pc_enable},     32'd0);
    check("beq_st1_pff", {31'd0, cw_d_pff_enable},    32'd0);
    check("beq_npc",     {29'd0, cw_f_npc_jump_mode}, 32'd1);
    tick();
    check("beq_st2_pc",  {31'd0, cw_f_pc_enable},  32'd0);
    check("beq_st2_pff", {31'd0, cw_d_pff_enable}, 32'd0);
    check("beq_bubble",  {31'd0, cw_e_m_alusrc},   32'd0);
    tick();
    check("beq_go_pc", {31'd0, cw_f_pc_enable}, 32'd1);
    check("beq_fmd1",  {29'd0, cw_fm_d1},       32'd5);
    check("beq_fmd2",  {29'd0, cw_fm_d2},       32'd5);
    check("lw_w_rd",   {29'd0, cw_w_m_regdata}, 32'd1);
    tick();
    // movz not taken: nothing written
    drive(MOVZ123, 32'd1);
    tick();
    drive(NOP, 32'd0);
    check("movzn_aluop", {27'd0, cw_e_alu_op}, 32'd4);
    tick();
    tick();
    check("movzn_w_we",   {31'd0, cw_w_rf_write_enable}, 32'd0);
    check("movzn_w_addr", {27'd0, cw_w_rf_write_addr},   32'd0);
    flush();

    // lw $1 then addu $4,$1,$2: one stall, then W2E
    drive(LW1, 32'd0);
    tick();
    drive(ADDU412, 32'd0);
    check("ldu_st_pc", {31'd0, cw_f_pc_enable}, 32'd0);
    tick();
    check("ldu_go_pc", {31'd0, cw_f_pc_enable}, 32'd1);
    check("ldu_fmd1",  {29'd0, cw_fm_d1},       32'd0);
    tick();
    drive(NOP, 32'd0);
    check("ldu_fme1", {29'd0, cw_fm_e1}, 32'd3);
    flush();

    // lw $1 then sw $1: no stall, W2M; then reset mid-run
    drive(LW1, 32'd0);
    tick();
    drive(SW1, 32'd0);
    check("lsw_pc_en", {31'd0, cw_f_pc_enable}, 32'd1);
    tick();
    drive(NOP, 32'd0);
    check("lsw_fme2", {29'd0, cw_fm_e2}, 32'd0);
    tick();
    check("lsw_fmm",   {29'd0, cw_fm_m},              32'd1);
    check("lsw_dm_we", {31'd0, cw_m_dm_write_enable}, 32'd1);
    check("lsw_w_rd",  {29'd0, cw_w_m_regdata},       32'd1);
    #1;
    reset = 1'b1;
    drive(BEQ11, 32'd0);
    check_idle("midrst");
    check("midrst_npc", {29'd0, cw_f_npc_jump_mode}, 32'd1);
    tick();
    reset = 1'b0;
    drive(NOP, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("post");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
Central controller for a 5-stage (F/D/E/M/W) MIPS-subset pipeline datapath. It decodes the D-stage instruction and carries it down internal E/M/W instruction registers. From these it produces per-stage control words, forwarding-mux selects and stall signals. It contains no datapath; the datapath feeds it the D instruction and the raw register-file rt read.

Parameters:
none

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears E/M/W instruction registers to nop
d_instr  in  32  instruction currently in D
rf_read_result2  in  32  raw RF read of rt for the D instruction (movz condition)
cw_f_pc_enable  out  1  PC write enable (0 = stall)
cw_d_pff_enable  out  1  F/D pipeline register enable (0 = stall)
cw_f_npc_jump_mode  out  3  0 PC+4, 1 beq, 2 j/jal index, 3 jr
cw_d_ext_mode  out  3  0 zero-ext, 1 sign-ext, 2 imm<<16
cw_d_rf_read_addr1  out  5  rs of d_instr
cw_d_rf_read_addr2  out  5  rt of d_instr
cw_e_m_alusrc  out  1  ALU B source: 0 register, 1 extended immediate
cw_e_alu_op  out  5  0 add, 1 sub, 2 or, 3 pass B, 4 pass A
cw_m_dm_write_enable  out  1  sw in M
cw_w_rf_write_enable  out  1  W instruction writes RF with a nonzero address
cw_w_m_regdata  out  3  0 ALU result, 1 DM data, 2 PC+8
cw_w_rf_write_addr  out  5  resolved destination of W instruction
cw_fm_d1, cw_fm_d2  out  3  D operand select: 0 RF, 1 E2D_rf, 2 E2D_npc, 3 M2D_alu, 4 M2D_npc, 5 W2D_rf
cw_fm_e1, cw_fm_e2  out  3  E operand select: 0 pipe reg, 1 M2E_alu, 2 M2E_npc, 3 W2E_rf
cw_fm_m  out  3  M store-data select: 0 pipe reg, 1 W2M_rf

Behaviour:
- Decode rules:
  - R-type opcode 0: funct 0x21 addu, 0x23 subu, 0x0A movz, 0x08 jr.
  - Opcodes: 0x0F lui, 0x0D ori, 0x23 lw, 0x2B sw, 0x04 beq, 0x02 j; jal is opcode 0x03 or 0x0B.
  - All-zero word and any unrecognised encoding are nop: no writes, no jumps.
- Destination:
  - rd for addu/subu/movz; rt for lui/ori/lw; 31 for jal.
  - movz resolves in D: destination = rd if rf_read_result2 == 0, else 0 (no write).
  - Resolved destination 0 means no write; cw_w_rf_write_enable = 0 in that case.
- ALU use:
  - addu: add, register B. subu: sub. ori: or, immediate, zero-ext. lui: pass B, ext mode 2.
  - lw/sw: add, immediate, sign-ext. beq: sign-ext. movz: pass A.
  - Write-data source: lw uses DM; jal uses PC+8; all others use ALU.
- Timing:
  - D outputs are combinational from d_instr.
  - E/M/W outputs are combinational from the internal E/M/W registers.
  - On each rising edge the registers shift D→E→M→W.
- Readiness of results:
  - In E: movz (its rs operand, E2D_rf) and jal (PC+8) are ready. ALU and lw results are not ready.
  - In M: ALU (M2*_alu) and jal (M2*_npc) results are ready; lw results are not ready.
  - In W: all results are ready (*_rf).
- Operand use points:
  - beq and jr consume rs/rt in D.
  - ALU instructions and lw/sw base consume operands in E.
  - sw rt consumes its operand in M.
- Forwarding:
  - Select the youngest matching producer whose nonzero resolved destination equals the source register.
  - Register 0 is never forwarded.
  - If the youngest match is not ready, D select = 0.
  - fm_d is computed for every D instruction that reads rs/rt; fm_e for the E instruction; fm_m for an sw in M.
  - The register file has no internal bypass, so W2D/W2E/W2M are required.
- Stall:
  - Stall when a D source is needed before its youngest producer is ready:
    - beq/jr vs an ALU or lw producer in E;
    - beq/jr vs lw in M;
    - E-use operand vs lw in E.
  - sw rt vs lw in E does not stall; it is covered by W2M.
  - During a stall: pc_enable = 0, pff_enable = 0, a nop is loaded into E, M/W advance, and the D outputs still reflect d_instr.
  - Otherwise both enables are 1.
- Reset: E/M/W registers become nop and all E/M/W control outputs are 0; D outputs follow d_instr.

Test Plan:
- reset high mid-run → all E/M/W outputs 0; after release, nop stream keeps all write enables 0 and fm_* 0.
- movz $1,$2,$3 (0x0043080a, reg2=0), then addu $0,$1,$1 (0x00210021, reg2=1) → next cycle fm_d1=fm_d2=1; following cycle fm_e1=fm_e2=1; movz in W: write_enable=1, addr=1, regdata=0.
- jal (0x2c000004), then addu $0,$31,$31 (0x03ff0021) → fm_d1=fm_d2=2, then fm_e1=fm_e2=2; npc_jump_mode=2 while jal in D; W addr 31, regdata 2.
- jal, nop, addu $0,$31,$31 → fm_d=4 with jal in M; next cycle fm_e=3.
- addu $1,$2,$3 (0x00430821), then sw $1,16($2) (0xac410010) → fm_e2=1, then fm_m=1 with dm_write_enable=1; no stall.
- lw $1,8($2), then beq $1,$1,x → two stall cycles (pc_enable=0, pff_enable=0), then fm_d1=fm_d2=5; movz with reg2=1 → write_enable stays 0.
